// File: rtl/mini_alu_16bit_muladd_if.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_16bit_muladd_if
// Description : Request/result bundle for the 16x16 multiply-accumulate unit.
//               The master drives operands and start; the slave returns the
//               32-bit result, overflow flag and busy/valid status.
// Revision    : 1.0 - initial release
// ============================================================================
interface mini_alu_16bit_muladd_if;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] C;
    logic        sign;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic        overflow;
    logic        busy;
    logic        valid;

    modport master (
        output start, X, Y, C, sign,
        input  prod_hi, prod_lo, overflow, busy, valid
    );

    modport slave (
        input  start, X, Y, C, sign,
        output prod_hi, prod_lo, overflow, busy, valid
    );
endinterface
`default_nettype wire

// File: rtl/mini_alu_16bit_muladd.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_16bit_muladd
// Description : Sequential 16x16 shift-add multiply-accumulate, R = X*Y + C,
//               unsigned or two's complement. Works on operand magnitudes and
//               applies the product sign in the final cycle. 17 cycles from
//               accept to a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_alu_16bit_muladd (
    input  wire logic                 clk,
    input  wire logic                 rst,
    mini_alu_16bit_muladd_if.slave    bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;
    localparam logic [3:0] c_LAST_STEP = 4'd15;

    logic [1:0]  r_state;
    logic [3:0]  r_count;
    logic [32:0] r_acc;
    logic [15:0] r_mcand;     // |X|, added into the upper half each step
    logic [15:0] r_c;
    logic        r_sign;
    logic        r_neg;
    logic [15:0] r_prod_hi;
    logic [15:0] r_prod_lo;
    logic        r_overflow;
    logic        r_valid;

    // Operand magnitudes; 0x8000 maps to itself, which is the correct
    // unsigned magnitude, so no saturation is needed.
    logic [15:0] w_x_mag;
    logic [15:0] w_y_mag;
    assign w_x_mag = (bus.sign && bus.X[15]) ? (16'd0 - bus.X) : bus.X;
    assign w_y_mag = (bus.sign && bus.Y[15]) ? (16'd0 - bus.Y) : bus.Y;

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping the carry in bit 32), then shift the whole accumulator.
    logic [16:0] w_add_sum;
    logic [32:0] w_acc_next;
    assign w_add_sum  = {1'b0, r_acc[31:16]} + {1'b0, r_mcand};
    assign w_acc_next = r_acc[0] ? {1'b0, w_add_sum, r_acc[15:1]}
                                 : {1'b0, r_acc[32:1]};

    // Final result: signed product plus extended addend, modulo 2^32.
    logic [31:0] w_prod_signed;
    logic [31:0] w_c_ext;
    logic [31:0] w_result;
    logic        w_overflow;
    assign w_prod_signed = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_c_ext       = r_sign ? {{16{r_c[15]}}, r_c} : {16'd0, r_c};
    assign w_result      = w_prod_signed + w_c_ext;
    assign w_overflow    = r_sign ? (w_result[31:16] != {16{w_result[15]}})
                                  : (w_result[31:16] != 16'd0);

    // Control FSM, datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= 4'd0;
            r_acc      <= 33'd0;
            r_mcand    <= 16'd0;
            r_c        <= 16'd0;
            r_sign     <= 1'b0;
            r_neg      <= 1'b0;
            r_prod_hi  <= 16'd0;
            r_prod_lo  <= 16'd0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= {17'd0, w_y_mag};
                        r_mcand <= w_x_mag;
                        r_c     <= bus.C;
                        r_sign  <= bus.sign;
                        r_neg   <= bus.sign & (bus.X[15] ^ bus.Y[15]);
                        r_count <= 4'd0;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 4'd1;
                    if (r_count == c_LAST_STEP) begin
                        r_state <= c_ST_FIN;
                    end
                end
                c_ST_FIN: begin
                    r_prod_hi  <= w_result[31:16];
                    r_prod_lo  <= w_result[15:0];
                    r_overflow <= w_overflow;
                    r_valid    <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.prod_hi  = r_prod_hi;
    assign bus.prod_lo  = r_prod_lo;
    assign bus.overflow = r_overflow;
    assign bus.valid    = r_valid;
    assign bus.busy     = (r_state == c_ST_CALC) || (r_state == c_ST_FIN);

endmodule
`default_nettype wire

// File: doc/mini_alu_16bit_muladd.md
# mini_ALU_16bit_MULADD

Sequential 16x16 shift-add multiply-accumulate unit for the mini ALU. It computes R = X*Y + C, with a 32-bit result, in unsigned or two's-complement mode. It is the inverse of the restoring divider: feeding it quot, Y and rem must rebuild the dividend. It sits beside the divider in the ALU datapath, serves MUL/MAC opcodes, and provides divider round-trip checking.

## Interface
Parameters: none. Width is fixed at 16-bit operands and a 32-bit result.
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; accepted only in IDLE
- X  input  16  multiplicand
- Y  input  16  multiplier
- C  input  16  addend; zero-extended if sign=0, sign-extended if sign=1
- sign  input  1  0 = unsigned, 1 = two's complement (applies to X, Y and C)
- prod_hi  output  16  result bits [31:16]
- prod_lo  output  16  result bits [15:0]
- overflow  output  1  result does not fit in 16 bits (see Operation)
- busy  output  1  high in CALC and FIN
- valid  output  1  one-cycle pulse when a new result is on the outputs

## Operation
- States: IDLE, CALC, FIN. State is encoded in 2 bits, and the unused code returns to IDLE.
- IDLE:
  - On start=1, latch X, Y, C and sign. Go to CALC with count=0.
  - Load acc[32:0] = {17'd0, |Y|}, where |.| is the magnitude if sign=1 and the raw value otherwise.
  - Record neg = sign & (X[15]^Y[15]).
  - Magnitude of 0x8000 is 0x8000 (unsigned 16-bit); it must not saturate.
- CALC, each cycle:
  - If acc[0]=1, set acc[32:16] = acc[31:16] + |X|.
  - Then shift acc right by 1.
  - Increment count. After the 16th CALC cycle (count=15), go to FIN.
- FIN, one cycle:
  - P = acc[31:0].
  - R = (neg ? -P : P) + ext(C), modulo 2^32.
  - Load R into prod_hi/prod_lo and set overflow.
  - Pulse valid and go to IDLE.
- The full 32-bit result never overflows in either mode: unsigned max is 0xFFFF0000, signed range is within ±2^30 + 2^15.
- overflow rules:
  - sign=0: overflow = (R[31:16] != 0).
  - sign=1: overflow = (R[31:16] != {16{R[15]}}).
- prod_hi, prod_lo and overflow are dedicated registers, written only in FIN. They hold their value until the next FIN. Internal acc activity is never visible on them.
- Operand inputs changing while busy=1 have no effect.
- start while busy=1 is ignored. It is not queued.

## Timing
- Reset values: all outputs 0, state IDLE, count 0, acc 0.
- Reset mid-operation aborts with no valid pulse, and the outputs return to 0.
- Reset has priority over start in the same cycle.
- Accept edge E0: start=1 sampled in IDLE. busy goes high after E0.
- E1..E16: CALC. E17: FIN edge.
- After E17: new outputs are stable, valid=1 and busy=0.
- Latency is 17 cycles from the accept edge to valid. valid is high for exactly 1 cycle.
- start=1 during the valid cycle is accepted (state is IDLE). That gives back-to-back operations with a throughput of one result per 18 cycles.
- busy stays low for the whole IDLE period, including the valid cycle.

## Test plan
- Unsigned max: sign=0, X=0xFFFF, Y=0xFFFF, C=0xFFFF.
  - Required: prod_hi=0xFFFF, prod_lo=0x0000, overflow=1.
  - valid arrives exactly 17 cycles after the accept edge.
- Signed corner: sign=1, X=0x8000, Y=0x8000, C=0xFFFF.
  - Required: {hi,lo}=0x3FFFFFFF, overflow=1.
- Signed small: sign=1, X=0xFFFD (-3), Y=0x0005, C=0x0002.
  - Required: {hi,lo}=0xFFFFFFF3, overflow=0.
- Divider round trip: sign=0, X=0x0123, Y=0x0045, C=0x0012.
  - Required: {hi,lo}=0x00004E81, overflow=0.
  - Repeat with random X/Y through divider then MULADD; required: prod_lo equals the original dividend, prod_hi=0.
- Protocol:
  - start pulsed with new operands at E5 of a running operation: ignored; the result matches the first operands only.
  - start during the valid cycle: a second result arrives 18 cycles after the first valid.
  - Operand inputs toggled while busy: no effect on the result.
- Reset: rst=1 at E8 of an operation.
  - Required: next cycle all outputs 0 and busy=0, and no valid pulse follows.
  - A new start afterwards produces a correct result.
